// File: rtl/id_branch_resolver_pkg.sv
// rtl/id_branch_resolver_pkg.sv - shared opcode, funct3, NOP and FSM state definitions
package id_branch_resolver_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_WAIT2 = 2'b01,
    ST_WAIT1 = 2'b10
  } state_t;

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - conditional-branch comparator selected by funct3
module branch_cmp
  import id_branch_resolver_pkg::*;
#(
  parameter int BUS_WIDTH = 64
) (
  input  logic [BUS_WIDTH-1:0] rs1_data,
  input  logic [BUS_WIDTH-1:0] rs2_data,
  input  logic [2:0]           funct3,
  output logic                 taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_data == rs2_data);
      F3_BNE:  taken = (rs1_data != rs2_data);
      F3_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: taken = (rs1_data <  rs2_data);
      F3_BGEU: taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_branch_resolver.sv
// rtl/id_branch_resolver.sv - ID register plus early branch/jump resolution with load-use stall
module id_branch_resolver
  import id_branch_resolver_pkg::*;
#(
  parameter int BUS_WIDTH   = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BUS_WIDTH-1:0]   if_pc,
  input  logic [INSTR_WIDTH-1:0] if_instr,
  input  logic                   branch_prediction_failed,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_rd,
  input  logic                   mem_is_load,
  input  logic [4:0]             mem_rd,
  output logic [4:0]             rs1_addr,
  output logic [4:0]             rs2_addr,
  input  logic [BUS_WIDTH-1:0]   rs1_data,
  input  logic [BUS_WIDTH-1:0]   rs2_data,
  output logic                   stall,
  output logic                   imm_pc,
  output logic [BUS_WIDTH-1:0]   next_imm_pc,
  output logic                   id_branch_taken,
  output logic [BUS_WIDTH-1:0]   id_pc,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic                   id_valid
);

  state_t state, state_next;

  logic [6:0]           opcode;
  logic                 is_branch, is_jal, is_jalr, is_ctrl;
  logic                 uses_rs1, uses_rs2;
  logic                 ex_hit, mem_hit;
  logic                 cmp_taken;
  logic                 resolve;
  logic                 stall_raw;
  logic [BUS_WIDTH-1:0] imm_b, imm_j, imm_i;
  logic [BUS_WIDTH-1:0] pc_target, jalr_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_instr <= INSTR_WIDTH'(NOP_INSTR);
    end else if (!stall) begin
      if (branch_prediction_failed) begin
        id_valid <= 1'b0;
        id_pc    <= if_pc;
        id_instr <= INSTR_WIDTH'(NOP_INSTR);
      end else begin
        id_valid <= 1'b1;
        id_pc    <= if_pc;
        id_instr <= if_instr;
      end
    end
  end

  assign opcode    = id_instr[6:0];
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_ctrl   = is_branch | is_jal | is_jalr;
  assign uses_rs1  = is_branch | is_jalr;
  assign uses_rs2  = is_branch;

  assign rs1_addr = id_instr[19:15];
  assign rs2_addr = id_instr[24:20];

  // x0 is hardwired zero, so a load "targeting" it never creates a dependency
  assign ex_hit  = ex_is_load && (ex_rd != 5'd0) &&
                   ((uses_rs1 && ex_rd == rs1_addr) || (uses_rs2 && ex_rd == rs2_addr));
  assign mem_hit = mem_is_load && (mem_rd != 5'd0) &&
                   ((uses_rs1 && mem_rd == rs1_addr) || (uses_rs2 && mem_rd == rs2_addr));

  assign imm_b = {{(BUS_WIDTH-12){id_instr[31]}}, id_instr[7], id_instr[30:25],
                  id_instr[11:8], 1'b0};
  assign imm_j = {{(BUS_WIDTH-20){id_instr[31]}}, id_instr[19:12], id_instr[20],
                  id_instr[30:21], 1'b0};
  assign imm_i = {{(BUS_WIDTH-12){id_instr[31]}}, id_instr[31:20]};

  assign pc_target = id_pc + (is_branch ? imm_b : imm_j);
  assign jalr_sum  = rs1_data + imm_i;

  branch_cmp #(.BUS_WIDTH(BUS_WIDTH)) u_cmp (
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .funct3   (id_instr[14:12]),
    .taken    (cmp_taken)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall_raw  = 1'b0;
    resolve    = 1'b0;
    case (state)
      ST_RUN: begin
        if (id_valid && is_ctrl) begin
          if (ex_hit) begin
            state_next = ST_WAIT2;
            stall_raw  = 1'b1;
          end else if (mem_hit) begin
            state_next = ST_WAIT1;
            stall_raw  = 1'b1;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      ST_WAIT2: begin
        state_next = ST_WAIT1;
        stall_raw  = 1'b1;
      end
      ST_WAIT1: begin
        state_next = ST_RUN;
        stall_raw  = 1'b1;
      end
      default: state_next = ST_RUN;
    endcase
  end

  assign stall           = stall_raw & id_valid;
  assign imm_pc          = id_valid & resolve & (is_jal | is_jalr | (is_branch & cmp_taken));
  assign id_branch_taken = id_valid & resolve & is_branch & cmp_taken;

  always_comb begin
    next_imm_pc = '0;
    if (imm_pc) next_imm_pc = is_jalr ? {jalr_sum[BUS_WIDTH-1:1], 1'b0} : pc_target;
  end

endmodule

// File: tb/tb_id_branch_resolver.sv
// tb/tb_id_branch_resolver.sv - directed self-checking bench for id_branch_resolver
module tb_id_branch_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        branch_prediction_failed;
  logic        ex_is_load, mem_is_load;
  logic [4:0]  ex_rd, mem_rd;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [63:0] rs1_data, rs2_data;
  logic        stall, imm_pc, id_branch_taken, id_valid;
  logic [63:0] next_imm_pc, id_pc;
  logic [31:0] id_instr;

  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  id_branch_resolver #(.BUS_WIDTH(64), .INSTR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_instr(if_instr),
    .branch_prediction_failed(branch_prediction_failed),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .mem_is_load(mem_is_load), .mem_rd(mem_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .stall(stall), .imm_pc(imm_pc), .next_imm_pc(next_imm_pc),
    .id_branch_taken(id_branch_taken), .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid)
  );

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_redirect(input string tag, input logic e_imm, input logic e_taken,
                              input logic [63:0] e_target, input logic e_stall);
    chk({tag, ".imm_pc"}, {63'd0, imm_pc}, {63'd0, e_imm});
    chk({tag, ".taken"}, {63'd0, id_branch_taken}, {63'd0, e_taken});
    chk({tag, ".target"}, next_imm_pc, e_target);
    chk({tag, ".stall"}, {63'd0, stall}, {63'd0, e_stall});
  endtask

  initial begin
    rst_n = 1'b0; if_pc = '0; if_instr = 32'h00000013; branch_prediction_failed = 1'b0;
    ex_is_load = 1'b0; ex_rd = '0; mem_is_load = 1'b0; mem_rd = '0;
    rs1_data = '0; rs2_data = '0;

    tick(); tick();
    chk("rst.id_valid", {63'd0, id_valid}, 64'd0);
    chk("rst.id_pc", id_pc, 64'd0);
    chk("rst.id_instr", {32'd0, id_instr}, 64'h13);
    chk_redirect("rst", 1'b0, 1'b0, 64'd0, 1'b0);

    // BEQ x1,x2,+16 at 0x100 taken, then not taken with unequal operands
    rst_n = 1'b1; if_pc = 64'h100; if_instr = enc_b(13'd16, 5'd2, 5'd1, 3'b000);
    tick();
    rs1_data = 64'd5; rs2_data = 64'd5; #1;
    chk("beq.id_valid", {63'd0, id_valid}, 64'd1);
    chk("beq.id_pc", id_pc, 64'h100);
    chk("beq.rs1_addr", {59'd0, rs1_addr}, 64'd1);
    chk("beq.rs2_addr", {59'd0, rs2_addr}, 64'd2);
    chk_redirect("beq_eq", 1'b1, 1'b1, 64'h110, 1'b0);
    rs2_data = 64'd6; #1;
    chk_redirect("beq_ne", 1'b0, 1'b0, 64'd0, 1'b0);

    // BLT -1 < 1 signed taken, backward offset -8
    if_pc = 64'h200; if_instr = enc_b(13'h1FF8, 5'd6, 5'd5, 3'b100);
    tick();
    rs1_data = 64'hFFFF_FFFF_FFFF_FFFF; rs2_data = 64'd1; #1;
    chk_redirect("blt", 1'b1, 1'b1, 64'h1F8, 1'b0);

    // BLTU same operands: 0xFF..FF is not below 1
    if_pc = 64'h204; if_instr = enc_b(13'h1FF8, 5'd6, 5'd5, 3'b110);
    tick(); #1;
    chk_redirect("bltu", 1'b0, 1'b0, 64'd0, 1'b0);

    // BGEU same operands taken
    if_pc = 64'h208; if_instr = enc_b(13'd8, 5'd6, 5'd5, 3'b111);
    tick(); #1;
    chk_redirect("bgeu", 1'b1, 1'b1, 64'h210, 1'b0);

    // funct3 010 never taken even with equal operands
    if_pc = 64'h20C; if_instr = enc_b(13'd8, 5'd6, 5'd5, 3'b010);
    tick();
    rs1_data = 64'd9; rs2_data = 64'd9; #1;
    chk_redirect("f3_010", 1'b0, 1'b0, 64'd0, 1'b0);

    // JAL -0x100: rs1 field bits are all ones, an in-flight load to x31 must not stall
    if_pc = 64'h300; if_instr = enc_jal(21'h1FFF00, 5'd1);
    tick();
    ex_is_load = 1'b1; ex_rd = 5'd31; #1;
    chk_redirect("jal", 1'b1, 1'b0, 64'h200, 1'b0);
    ex_is_load = 1'b0; ex_rd = 5'd0;

    // JALR imm 3 from 0x1000: bit 0 cleared
    if_pc = 64'h310; if_instr = enc_jalr(12'd3, 5'd5, 5'd1);
    tick();
    rs1_data = 64'h1000; #1;
    chk_redirect("jalr", 1'b1, 1'b0, 64'h1002, 1'b0);

    // BEQ x0,x0 with a load to x0 in EX: no hazard, taken
    if_pc = 64'h320; if_instr = enc_b(13'd4, 5'd0, 5'd0, 3'b000);
    tick();
    ex_is_load = 1'b1; ex_rd = 5'd0; rs1_data = 64'd0; rs2_data = 64'd0; #1;
    chk_redirect("x0_haz", 1'b1, 1'b1, 64'h324, 1'b0);

    // ADDI x1,x1,1 with a load to x1 in EX: non-control never stalls
    ex_rd = 5'd1;
    if_pc = 64'h330; if_instr = 32'h00108093;
    tick(); #1;
    chk_redirect("addi_haz", 1'b0, 1'b0, 64'd0, 1'b0);
    ex_is_load = 1'b0; ex_rd = 5'd0;

    // BNE x3,x4,+8 behind a load to x3 in EX; a flush during the stall is ignored
    if_pc = 64'h400; if_instr = enc_b(13'd8, 5'd4, 5'd3, 3'b001);
    tick();
    ex_is_load = 1'b1; ex_rd = 5'd3; #1;
    chk_redirect("bne_detect", 1'b0, 1'b0, 64'd0, 1'b1);
    branch_prediction_failed = 1'b1; if_pc = 64'h404; if_instr = 32'h00000013;
    tick();
    ex_is_load = 1'b0; ex_rd = 5'd0; branch_prediction_failed = 1'b0; #1;
    chk("bne_hold.id_valid", {63'd0, id_valid}, 64'd1);
    chk("bne_hold.id_pc", id_pc, 64'h400);
    chk_redirect("bne_wait_a", 1'b0, 1'b0, 64'd0, 1'b1);
    tick();
    chk_redirect("bne_wait_b", 1'b0, 1'b0, 64'd0, 1'b1);
    tick();
    rs1_data = 64'd1; rs2_data = 64'd2; #1;
    chk_redirect("bne_resolve", 1'b1, 1'b1, 64'h408, 1'b0);

    // BEQ x8,x9,+32 behind a load to x9 in MEM (rs2 source)
    if_pc = 64'h500; if_instr = enc_b(13'd32, 5'd9, 5'd8, 3'b000);
    tick();
    mem_is_load = 1'b1; mem_rd = 5'd9; #1;
    chk_redirect("mem_detect", 1'b0, 1'b0, 64'd0, 1'b1);
    tick();
    mem_is_load = 1'b0; mem_rd = 5'd0; #1;
    chk_redirect("mem_wait", 1'b0, 1'b0, 64'd0, 1'b1);
    tick();
    rs1_data = 64'd7; rs2_data = 64'd7; #1;
    chk_redirect("mem_resolve", 1'b1, 1'b1, 64'h520, 1'b0);

    // Flush with no stall: bubble and no redirect
    if_pc = 64'h540; if_instr = enc_jal(21'd64, 5'd1);
    branch_prediction_failed = 1'b1;
    tick();
    branch_prediction_failed = 1'b0; #1;
    chk("flush.id_valid", {63'd0, id_valid}, 64'd0);
    chk("flush.id_instr", {32'd0, id_instr}, 64'h13);
    chk_redirect("flush", 1'b0, 1'b0, 64'd0, 1'b0);

    // JALR behind an EX load, reset while in WAIT2
    if_pc = 64'h600; if_instr = enc_jalr(12'd0, 5'd5, 5'd1);
    tick();
    ex_is_load = 1'b1; ex_rd = 5'd5; #1;
    chk_redirect("rw_detect", 1'b0, 1'b0, 64'd0, 1'b1);
    if_pc = 64'h604; if_instr = 32'h00000013;
    tick();
    ex_is_load = 1'b0; ex_rd = 5'd0; #1;
    chk_redirect("rw_wait2", 1'b0, 1'b0, 64'd0, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("rw_rst.id_valid", {63'd0, id_valid}, 64'd0);
    chk("rw_rst.id_pc", id_pc, 64'd0);
    chk("rw_rst.id_instr", {32'd0, id_instr}, 64'h13);
    chk_redirect("rw_rst", 1'b0, 1'b0, 64'd0, 1'b0);

    // After reset the FSM is in RUN: a fresh JALR resolves immediately
    rst_n = 1'b1; if_pc = 64'h700; if_instr = enc_jalr(12'd16, 5'd5, 5'd0);
    tick();
    rs1_data = 64'h2000; #1;
    chk_redirect("post_rst", 1'b1, 1'b0, 64'h2010, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
